// File: rtl/fc_classifier_if.sv
// Handshake and ROM bus of the fully connected classifier: start/feature vector in,
// weight ROM address/data, and the classification result.
interface fc_classifier_if #(
  parameter int N_IN  = 26,
  parameter int N_OUT = 4,
  parameter int ACC_W = 24,
  parameter int AW    = $clog2(N_OUT*(N_IN+1)),
  parameter int CW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
  logic                    start;
  logic [N_IN-1:0][7:0]    input_vector;
  logic [AW-1:0]           w_addr;
  logic signed [7:0]       w_data;
  logic                    busy;
  logic                    done;
  logic [CW-1:0]           class_idx;
  logic signed [ACC_W-1:0] class_score;

  modport master (
    output start, input_vector, w_data,
    input  w_addr, busy, done, class_idx, class_score
  );

  modport slave (
    input  start, input_vector, w_data,
    output w_addr, busy, done, class_idx, class_score
  );
endinterface

// File: rtl/fc_classifier.sv
// Fully connected output layer with argmax: one dot product plus bias per class,
// weights streamed from a 1-cycle-latency ROM, winning index and score reported.
module fc_classifier #(
  parameter int N_IN  = 26,
  parameter int N_OUT = 4,
  parameter int ACC_W = 24,
  parameter int AW    = $clog2(N_OUT*(N_IN+1))
) (
  input  logic            clk,
  input  logic            rst,
  fc_classifier_if.slave  bus
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int IW     = $clog2(N_IN+2);
  localparam int CW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMPARE, S_DONE} state_t;

  state_t r_state, w_state_nx;

  logic signed [DATA_W-1:0] r_x [N_IN];
  logic [IW-1:0]            r_in_idx;
  logic [CW-1:0]            r_out_idx;
  logic [AW-1:0]            r_w_addr;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_best_score;
  logic [CW-1:0]            r_best_idx;
  logic [CW-1:0]            r_class_idx;
  logic signed [ACC_W-1:0]  r_class_score;
  logic                     r_vld_p0;
  logic                     r_bias_p0;
  logic [IW-1:0]            r_j_p0;

  logic                     w_busy;
  logic                     w_done;
  logic                     w_last_w;
  logic                     w_last_n;
  logic                     w_take;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_best_score_nx;
  logic [CW-1:0]            w_best_idx_nx;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [DATA_W-1:0] x,
                                                       input logic signed [COEF_W-1:0] w);
    logic signed [DATA_W+COEF_W-1:0] p;
    p = x * w;
    return ACC_W'(p);
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_bias(input logic signed [COEF_W-1:0] b);
    return ACC_W'(b);
  endfunction

  assign w_last_w = (r_in_idx == IW'(N_IN));
  assign w_last_n = (r_out_idx == CW'(N_OUT-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.start) w_state_nx = S_LOAD;
      S_LOAD:    if (w_last_w) w_state_nx = S_DRAIN;
      S_DRAIN:   w_state_nx = S_COMPARE;
      S_COMPARE: w_state_nx = w_last_n ? S_DONE : S_LOAD;
      S_DONE:    w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
  end

  // Stage p0: ROM data returns one cycle after its address; j and the bias flag travel with it.
  always_comb begin
    w_term = r_bias_p0 ? sext_bias(bus.w_data) : mac_term(r_x[r_j_p0], bus.w_data);
  end

  always_comb begin
    w_take          = (r_out_idx == '0) || (r_acc > r_best_score);
    w_best_score_nx = w_take ? r_acc : r_best_score;
    w_best_idx_nx   = w_take ? r_out_idx : r_best_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
      r_in_idx      <= '0;
      r_out_idx     <= '0;
      r_w_addr      <= '0;
      r_acc         <= '0;
      r_best_score  <= '0;
      r_best_idx    <= '0;
      r_class_idx   <= '0;
      r_class_score <= '0;
      r_vld_p0      <= 1'b0;
      r_bias_p0     <= 1'b0;
      r_j_p0        <= '0;
    end else begin
      r_vld_p0  <= (r_state == S_LOAD);
      r_bias_p0 <= (r_state == S_LOAD) && w_last_w;
      r_j_p0    <= r_in_idx;
      if (r_vld_p0) r_acc <= r_acc + w_term;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= bus.input_vector[i];
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_acc     <= '0;
            r_w_addr  <= '0;
          end
        end
        S_LOAD: begin
          r_in_idx <= r_in_idx + IW'(1);
          // Hold the bias address through DRAIN/COMPARE; the next neuron starts right after it.
          if (!w_last_w) r_w_addr <= r_w_addr + AW'(1);
        end
        S_COMPARE: begin
          r_best_score <= w_best_score_nx;
          r_best_idx   <= w_best_idx_nx;
          r_acc        <= '0;
          r_in_idx     <= '0;
          if (w_last_n) begin
            r_class_idx   <= w_best_idx_nx;
            r_class_score <= w_best_score_nx;
            r_w_addr      <= '0;
          end else begin
            r_out_idx <= r_out_idx + CW'(1);
            r_w_addr  <= r_w_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.w_addr      = r_w_addr;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.class_idx   = r_class_idx;
  assign bus.class_score = r_class_score;
endmodule
